// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle for mem_access_ctrl.
// The master side issues requests and consumes responses; the slave side is the controller.
interface mem_access_ctrl_if #(
    parameter int unsigned LINE_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LINE_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: read, write and whole-memory fill over a valid/ready request port.
// Define MEM_ACCESS_CTRL_WRITE_ACK_EN to make writes and fills return an acknowledge response.
module mem_access_ctrl #(
    parameter int unsigned CELL_COUNT = 256,
    parameter int unsigned LINE_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    mem_access_ctrl_if.slave      ctrl_io,
    output logic [ADDR_WIDTH-1:0] mem_read_address_o,
    input  logic [LINE_WIDTH-1:0] mem_read_data_i,
    output logic [ADDR_WIDTH-1:0] mem_write_address_o,
    output logic [LINE_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_enable_o
);

`ifdef MEM_ACCESS_CTRL_WRITE_ACK_EN
    localparam bit WriteAck = 1'b1;
`else
    localparam bit WriteAck = 1'b0;
`endif

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpFill  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(CELL_COUNT - 1);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StFill, StResp} state_e;

    state_e                state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [LINE_WIDTH-1:0] rsp_data_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [LINE_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] fill_cnt_q;
    logic                  addr_ok;

    assign addr_ok = 32'(ctrl_io.req_addr) < CELL_COUNT;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fill_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_io.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (ctrl_io.req_op == OpRead && addr_ok) begin
                            state_q   <= StRead;
                            rd_addr_q <= ctrl_io.req_addr;
                        end else if (ctrl_io.req_op == OpWrite && addr_ok) begin
                            state_q   <= StWrite;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= ctrl_io.req_addr;
                            wr_data_q <= ctrl_io.req_data;
                        end else if (ctrl_io.req_op == OpFill) begin
                            state_q    <= StFill;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= '0;
                            wr_data_q  <= ctrl_io.req_data;
                            fill_cnt_q <= '0;
                        end else begin
                            // Reserved op or out-of-range address: error response, no write.
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end
                    end
                end
                StRead: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= mem_read_data_i;
                end
                StWrite, StFill: begin
                    if (state_q == StWrite || fill_cnt_q == LastAddr) begin
                        wr_en_q    <= 1'b0;
                        fill_cnt_q <= '0;
                        if (WriteAck) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= StIdle;
                            req_ready_q <= 1'b1;
                        end
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        wr_addr_q  <= fill_cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (ctrl_io.rsp_ready) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    wr_en_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_io.req_ready   = req_ready_q;
    assign ctrl_io.rsp_valid   = rsp_valid_q;
    assign ctrl_io.rsp_err     = rsp_err_q;
    assign ctrl_io.rsp_data    = rsp_data_q;
    assign mem_read_address_o  = rd_addr_q;
    assign mem_write_enable_o  = wr_en_q;
    assign mem_write_address_o = wr_addr_q;
    assign mem_write_data_o    = wr_data_q;

endmodule
